// File: rtl/flash_port_arb.sv
// Arbitrates one quad-SPI flash between several SPI/QSPI masters: one owner at a time,
// forced idle gap between grants, optional grant timeout, pads parked when nobody drives.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no owner; pads parked; the first requester seen is granted
// ST_OWN  | one channel owns the pads while its chip select is low
// ST_GAP  | pads parked for pGAP cycles; new requests are held off

module flash_port_arb #(
    parameter int pCHANNELS = 2,
    parameter int pRR       = 1,
    parameter int pGAP      = 2,
    parameter int pTIMEOUT  = 0
) (
    input  logic                   iCLK,
    input  logic                   iRESETn,
    input  logic [pCHANNELS-1:0]   iREQ,
    output logic [pCHANNELS-1:0]   oGNT,
    input  logic [pCHANNELS-1:0]   iCS_N,
    input  logic [pCHANNELS-1:0]   iSCK,
    input  logic [4*pCHANNELS-1:0] iDO,
    input  logic [4*pCHANNELS-1:0] iOE,
    output logic [3:0]             oDI,
    output logic                   oFLASH_SCK,
    output logic                   oFLASH_CS_N,
    output logic [3:0]             oDQ_O,
    output logic [3:0]             oDQ_OE,
    input  logic [3:0]             iDQ_I,
    output logic                   oBUSY,
    output logic [2:0]             oOWNER,
    output logic                   oTIMEOUT
);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_GAP} state_t;

    localparam logic [7:0]  GAP_LOAD = 8'(pGAP - 1);
    localparam logic [23:0] TO_LOAD  = 24'(pTIMEOUT - 1);
    localparam logic [3:0]  PARK     = 4'b1100;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [pCHANNELS-1:0]   r_gnt;
    logic [2:0]             r_owner;
    logic [2:0]             r_rr_ptr;
    logic                   r_busy;
    logic                   r_timeout;
    logic [7:0]             r_gap_cnt;
    logic [23:0]            r_to_cnt;

    logic                   w_found;
    logic [2:0]             w_win_idx;
    logic [pCHANNELS-1:0]   w_win_oh;
    logic [2:0]             w_ptr_nxt;
    logic                   w_owner_req;
    logic                   w_to_hit;
    logic                   w_release;

    logic                   w_cs_n;
    logic                   w_sck;
    logic [3:0]             w_do;
    logic [3:0]             w_oe;
    logic                   w_live;

    // Winner is the requester at the smallest rotational distance from the pointer.
    always_comb begin
        int best;
        int d;
        best      = pCHANNELS;
        d         = 0;
        w_found   = |iREQ;
        w_win_idx = '0;
        w_win_oh  = '0;
        for (int c = 0; c < pCHANNELS; c++) begin
            d = (pRR != 0) ? c - int'(r_rr_ptr) : c;
            if (d < 0) d = d + pCHANNELS;
            if (iREQ[c] && (d < best)) begin
                best      = d;
                w_win_idx = 3'(c);
            end
        end
        for (int c = 0; c < pCHANNELS; c++) begin
            w_win_oh[c] = w_found && (w_win_idx == 3'(c));
        end
        w_ptr_nxt = (int'(w_win_idx) == pCHANNELS - 1) ? 3'd0 : w_win_idx + 3'd1;
    end

    assign w_owner_req = |(iREQ & r_gnt);
    assign w_to_hit    = (pTIMEOUT > 0) && (r_to_cnt == '0);
    assign w_release   = !w_owner_req || w_to_hit;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_found)            w_state_nxt = ST_OWN;
            ST_OWN:  if (w_release)          w_state_nxt = ST_GAP;
            ST_GAP:  if (r_gap_cnt == '0)    w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_win_oh;
                        r_owner  <= w_win_idx;
                        r_busy   <= 1'b1;
                        r_rr_ptr <= w_ptr_nxt;
                        r_to_cnt <= TO_LOAD;
                    end
                end
                ST_OWN: begin
                    if (w_release) begin
                        r_gnt     <= '0;
                        r_owner   <= '0;
                        r_busy    <= 1'b0;
                        // A drop coinciding with the timeout is an ordinary release.
                        r_timeout <= w_owner_req;
                        r_gap_cnt <= GAP_LOAD;
                    end else begin
                        r_to_cnt  <= r_to_cnt - 24'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_cs_n = 1'b1;
        w_sck  = 1'b0;
        w_do   = '0;
        w_oe   = '0;
        for (int c = 0; c < pCHANNELS; c++) begin
            if (r_gnt[c]) begin
                w_cs_n = iCS_N[c];
                w_sck  = iSCK[c];
                w_do   = iDO[4*c +: 4];
                w_oe   = iOE[4*c +: 4];
            end
        end
    end

    assign w_live      = (r_state == ST_OWN) && !w_cs_n;
    assign oFLASH_CS_N = !w_live;
    assign oFLASH_SCK  = w_live & w_sck;
    assign oDQ_O       = w_live ? w_do : PARK;
    assign oDQ_OE      = w_live ? w_oe : PARK;
    assign oDI         = iDQ_I;

    assign oGNT     = r_gnt;
    assign oBUSY    = r_busy;
    assign oOWNER   = r_owner;
    assign oTIMEOUT = r_timeout;

endmodule

// File: tb/tb_flash_port_arb.sv
// Bench for flash_port_arb: two instances (3ch round-robin with timeout, 4ch fixed priority)
// checked every cycle against a behavioural model, plus directed literal scenarios.

module tb_flash_port_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  req_a;
    logic [3:0]  req_b;
    logic [3:0]  cs_n;
    logic [3:0]  sck;
    logic [15:0] dout;
    logic [15:0] oe;
    logic [3:0]  dq_i;

    logic [2:0] gnt_a, own_a;
    logic [3:0] gnt_b;
    logic [2:0] own_b;
    logic [3:0] di_a, dqo_a, dqoe_a, di_b, dqo_b, dqoe_b;
    logic       fsck_a, fcsn_a, busy_a, to_a;
    logic       fsck_b, fcsn_b, busy_b, to_b;

    flash_port_arb #(.pCHANNELS(3), .pRR(1), .pGAP(2), .pTIMEOUT(16)) u_a (
        .iCLK(clk), .iRESETn(rst_n), .iREQ(req_a), .oGNT(gnt_a),
        .iCS_N(cs_n[2:0]), .iSCK(sck[2:0]), .iDO(dout[11:0]), .iOE(oe[11:0]),
        .oDI(di_a), .oFLASH_SCK(fsck_a), .oFLASH_CS_N(fcsn_a), .oDQ_O(dqo_a),
        .oDQ_OE(dqoe_a), .iDQ_I(dq_i), .oBUSY(busy_a), .oOWNER(own_a), .oTIMEOUT(to_a));

    flash_port_arb #(.pCHANNELS(4), .pRR(0), .pGAP(3), .pTIMEOUT(0)) u_b (
        .iCLK(clk), .iRESETn(rst_n), .iREQ(req_b), .oGNT(gnt_b),
        .iCS_N(cs_n), .iSCK(sck), .iDO(dout), .iOE(oe),
        .oDI(di_b), .oFLASH_SCK(fsck_b), .oFLASH_CS_N(fcsn_b), .oDQ_O(dqo_b),
        .oDQ_OE(dqoe_b), .iDQ_I(dq_i), .oBUSY(busy_b), .oOWNER(own_b), .oTIMEOUT(to_b));

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: mode 0 idle, 1 owned, 2 gap; held/gap counts go up from zero.
    int P_N[2]   = '{3, 4};
    int P_RR[2]  = '{1, 0};
    int P_GAP[2] = '{2, 3};
    int P_TO[2]  = '{16, 0};
    int m_mode[2]  = '{0, 0};
    int m_owner[2] = '{0, 0};
    int m_held[2]  = '{0, 0};
    int m_gapd[2]  = '{0, 0};
    int m_ptr[2]   = '{0, 0};
    int m_tout[2]  = '{0, 0};

    task automatic model_step(input int k, input logic [3:0] rq, input logic rstn);
        int win;
        int c;
        win = -1;
        if (!rstn) begin
            m_mode[k] = 0; m_owner[k] = 0; m_held[k] = 0;
            m_gapd[k] = 0; m_ptr[k] = 0; m_tout[k] = 0;
        end else begin
            case (m_mode[k])
                0: begin
                    m_tout[k] = 0;
                    for (int i = 0; i < P_N[k]; i++) begin
                        c = (P_RR[k] != 0) ? (m_ptr[k] + i) % P_N[k] : i;
                        if (win < 0 && rq[c]) win = c;
                    end
                    if (win >= 0) begin
                        m_mode[k] = 1; m_owner[k] = win; m_held[k] = 0;
                        m_ptr[k] = (win + 1) % P_N[k];
                    end
                end
                1: begin
                    m_held[k]++;
                    if (!rq[m_owner[k]]) begin
                        m_mode[k] = 2; m_gapd[k] = 0; m_tout[k] = 0;
                    end else if (P_TO[k] > 0 && m_held[k] >= P_TO[k]) begin
                        m_mode[k] = 2; m_gapd[k] = 0; m_tout[k] = 1;
                    end else begin
                        m_tout[k] = 0;
                    end
                end
                default: begin
                    m_tout[k] = 0;
                    m_gapd[k]++;
                    if (m_gapd[k] >= P_GAP[k]) m_mode[k] = 0;
                end
            endcase
        end
    endtask

    always @(posedge clk) begin
        model_step(0, {1'b0, req_a}, rst_n);
        model_step(1, req_b, rst_n);
    end

    task automatic compare_inst(input int k, input int gnt, input int own, input int busy,
                                input int tout, input int csn, input int fsck, input int dqo,
                                input int dqoe, input int di);
        string p;
        int    o;
        bit    live;
        p    = (k == 0) ? "A" : "B";
        o    = m_owner[k];
        live = (m_mode[k] == 1) && (cs_n[o] == 1'b0);
        check({p, " gnt"},     gnt,  (m_mode[k] == 1) ? (1 << o) : 0);
        check({p, " owner"},   own,  (m_mode[k] == 1) ? o : 0);
        check({p, " busy"},    busy, (m_mode[k] == 1) ? 1 : 0);
        check({p, " timeout"}, tout, m_tout[k]);
        check({p, " onehot"},  ($countones(gnt) <= 1) ? 1 : 0, 1);
        check({p, " cs_n"},    csn,  live ? 0 : 1);
        check({p, " sck"},     fsck, live ? int'(sck[o]) : 0);
        check({p, " dq_o"},    dqo,  live ? int'((dout >> (4*o)) & 16'hF) : 12);
        check({p, " dq_oe"},   dqoe, live ? int'((oe >> (4*o)) & 16'hF) : 12);
        check({p, " di"},      di,   int'(dq_i));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare_inst(0, gnt_a, own_a, busy_a, to_a, fcsn_a, fsck_a, dqo_a, dqoe_a, di_a);
            compare_inst(1, gnt_b, own_b, busy_b, to_b, fcsn_b, fsck_b, dqo_b, dqoe_b, di_b);
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int ha, hb;
        int ord_a[$];
        int ord_b[$];
        int exp_a[4] = '{0, 1, 2, 0};

        rst_n = 1'b0; req_a = '0; req_b = '0; cs_n = '1; sck = '0;
        dout = '0; oe = '0; dq_i = 4'h5;
        nxt(); nxt();
        chk_en = 1'b1;
        check("rst gnt", gnt_a, 0);
        check("rst cs_n", fcsn_a, 1);
        check("rst dq_oe", dqoe_a, 12);
        check("rst dq_o", dqo_b, 12);
        check("rst di", di_a, 5);

        // basic grant, mirror, release, gap
        rst_n = 1'b1; req_a = 3'b001; req_b = 4'b0001;
        nxt();
        check("lat gnt A", gnt_a, 1);
        check("lat gnt B", gnt_b, 1);
        check("lat busy", busy_a, 1);
        cs_n = 4'b1110; sck = 4'b0001; #1;
        check("mirror sck hi", fsck_a, 1);
        check("mirror cs lo", fcsn_a, 0);
        sck = 4'b1110; #1;
        check("no leak sck", fsck_a, 0);
        cs_n = 4'b1111; sck = '0; req_a = '0; req_b = '0;
        nxt();
        check("release gnt", gnt_a, 0);
        check("release busy", busy_a, 0);
        req_a = 3'b001; req_b = 4'b0001;
        nxt(); check("gap1 A", gnt_a, 0);
        nxt(); check("gap2 A", gnt_a, 0);
        nxt(); check("regrant A", gnt_a, 1); check("gap3 B", gnt_b, 0);
        nxt(); check("regrant B", gnt_b, 1);
        req_a = '0; req_b = '0;
        repeat (6) nxt();

        // arbitration order with all requesters held
        rst_n = 1'b0; nxt(); rst_n = 1'b1;
        req_a = 3'b111; req_b = 4'b0111; ha = 0; hb = 0;
        for (int t = 0; t < 150 && (ord_a.size() < 4 || ord_b.size() < 3); t++) begin
            nxt();
            if (gnt_a != 0) begin
                if (ha == 0) ord_a.push_back(int'(own_a));
                ha++;
                req_a = (ha >= 4) ? (3'b111 & ~gnt_a) : 3'b111;
            end else begin
                ha = 0; req_a = 3'b111;
            end
            if (gnt_b != 0) begin
                if (hb == 0) ord_b.push_back(int'(own_b));
                hb++;
                req_b = (hb >= 4) ? (4'b0111 & ~gnt_b) : 4'b0111;
            end else begin
                hb = 0; req_b = 4'b0111;
            end
        end
        check("rr count", ord_a.size(), 4);
        for (int i = 0; i < 4; i++) check("rr order", (i < ord_a.size()) ? ord_a[i] : -1, exp_a[i]);
        check("fixed count", ord_b.size(), 3);
        for (int i = 0; i < 3; i++) check("fixed order", (i < ord_b.size()) ? ord_b[i] : -1, 0);
        req_a = '0; req_b = '0;
        repeat (6) nxt();

        // timeout on channel 1
        rst_n = 1'b0; nxt(); rst_n = 1'b1;
        req_a = 3'b010; cs_n = 4'b1101;
        nxt();
        check("to grant", gnt_a, 2);
        check("to cs live", fcsn_a, 0);
        repeat (15) nxt();
        check("to hold gnt", gnt_a, 2);
        check("to not yet", to_a, 0);
        nxt();
        check("to pulse", to_a, 1);
        check("to revoke gnt", gnt_a, 0);
        check("to cs park", fcsn_a, 1);
        nxt(); check("to pulse width", to_a, 0);
        nxt(); nxt(); check("to regrant", gnt_a, 2);

        // quad read lanes, then park on chip-select release
        oe = 16'h000F; dout = 16'h00A5; cs_n = 4'b1100; #1;
        check("quad oe", dqoe_a, 0);
        check("quad do", dqo_a, 10);
        oe = 16'h003F; #1;
        check("lane oe follow", dqoe_a, 3);
        cs_n = 4'b1110; #1;
        check("cs hi oe park", dqoe_a, 12);
        check("cs hi do park", dqo_a, 12);
        check("cs hi cs_n", fcsn_a, 1);
        cs_n = 4'b1101; oe = '0; dout = '0;

        // drop and timeout on the same edge
        repeat (15) nxt();
        req_a = '0;
        nxt();
        check("drop+to no pulse", to_a, 0);
        check("drop+to gnt", gnt_a, 0);
        nxt(); check("drop+to later", to_a, 0);

        // reset while owning with chip select low
        req_a = 3'b010;
        for (int t = 0; t < 10 && gnt_a == 0; t++) nxt();
        check("pre-rst gnt", gnt_a, 2);
        check("pre-rst cs", fcsn_a, 0);
        rst_n = 1'b0;
        nxt();
        check("rst own cs_n", fcsn_a, 1);
        check("rst own gnt", gnt_a, 0);
        check("rst own owner", own_a, 0);
        check("rst own busy", busy_a, 0);
        rst_n = 1'b1; req_a = 3'b011;
        nxt();
        check("post-rst grant", gnt_a, 1);
        req_a = '0; cs_n = '1;

        // random traffic
        for (int t = 0; t < 3000; t++) begin
            nxt();
            rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            for (int c = 0; c < 3; c++) if ($urandom_range(0, 9) == 0) req_a[c] = ~req_a[c];
            for (int c = 0; c < 4; c++) if ($urandom_range(0, 9) == 0) req_b[c] = ~req_b[c];
            for (int c = 0; c < 4; c++) if ($urandom_range(0, 3) == 0) cs_n[c] = ~cs_n[c];
            sck  = 4'($urandom);
            dout = 16'($urandom);
            oe   = 16'($urandom);
            dq_i = 4'($urandom);
        end

        nxt();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/flash_port_arb.md
FLASH_PORT_ARB -- requirements
Module: flash_port_arb

Interface
REQ-001 SHALL have parameter pCHANNELS, default 2, number of requesting SPI/QSPI masters (legal range 2..8).
REQ-002 SHALL have parameter pRR, default 1: 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
REQ-003 SHALL have parameter pGAP, default 2: idle cycles forced between grants (legal range 1..255).
REQ-004 SHALL have parameter pTIMEOUT, default 0: maximum grant length in cycles; 0 disables the timeout (legal range 0..2^24-1).
REQ-005 SHALL have port iCLK, input, 1, the single clock.
REQ-006 SHALL have port iRESETn, input, 1, reset: synchronous, active-low.
REQ-007 SHALL have port iREQ, input, pCHANNELS, per-channel bus request, level-held.
REQ-008 SHALL have port oGNT, output, pCHANNELS, one-hot grant, registered.
REQ-009 SHALL have port iCS_N, input, pCHANNELS, per-channel chip select.
REQ-010 SHALL have port iSCK, input, pCHANNELS, per-channel serial clock.
REQ-011 SHALL have port iDO, input, 4*pCHANNELS, per-channel lane outputs; lane k of channel c is bit 4c+k.
REQ-012 SHALL have port iOE, input, 4*pCHANNELS, per-channel lane output enables, indexed as iDO.
REQ-013 SHALL have port oDI, output, 4, flash lane inputs broadcast to all channels.
REQ-014 SHALL have ports oFLASH_SCK (output, 1), oFLASH_CS_N (output, 1), oDQ_O (output, 4), oDQ_OE (output, 4) and iDQ_I (input, 4), forming the flash pad interface.
REQ-015 SHALL have port oBUSY, output, 1, high while a grant is held.
REQ-016 SHALL have port oOWNER, output, 3, binary index of the current owner; 0 when no owner.
REQ-017 SHALL have port oTIMEOUT, output, 1, single-cycle pulse on a forced revoke.

Function
REQ-018 SHALL implement the states IDLE, OWN and GAP; all state is updated on the rising edge of iCLK.
REQ-019 IDLE: if any iREQ bit is high at an edge, the arbiter SHALL select a winner and, at that edge, set oGNT (one-hot), oOWNER and oBUSY and enter OWN, so that grant latency is 1 cycle.
REQ-020 Fixed priority (pRR=0): the lowest-indexed requester SHALL win.
REQ-021 Round-robin (pRR=1): the search SHALL start at (last owner + 1) modulo pCHANNELS, wrapping past pCHANNELS-1 to 0; the pointer SHALL be 0 after reset.
REQ-022 OWN: the pad outputs SHALL be a combinational mux from the owner's iCS_N, iSCK, iDO and iOE; oDI SHALL equal iDQ_I at all times.
REQ-023 OWN -> GAP SHALL occur when the owner's iREQ is low at an edge; oGNT, oBUSY and oOWNER SHALL clear at that same edge.
REQ-024 If pTIMEOUT>0 and a grant has been held for pTIMEOUT cycles, the arbiter SHALL revoke it regardless of iREQ, pulse oTIMEOUT for 1 cycle and enter GAP.
REQ-025 GAP SHALL last exactly pGAP cycles, counted by a down-counter, then return to IDLE; requests raised during GAP SHALL be held off.
REQ-026 Parked pins (IDLE, GAP, or OWN while the owner's iCS_N=1): oFLASH_CS_N=1, oFLASH_SCK=0, oDQ_OE=4'b1100, oDQ_O=4'b1100, so that WP and HOLD are held high and lanes 0 and 1 are tristated.
REQ-027 In OWN with the owner's iCS_N=0, lanes 2 and 3 SHALL follow the owner's iOE and iDO with no parking, so that flash quad reads do not see contention.
REQ-028 A non-owner's iCS_N, iSCK, iDO and iOE SHALL never reach the pads.
REQ-029 Simultaneous events: the owner dropping iREQ while another channel raises iREQ in the same cycle SHALL go to GAP, and the new grant SHALL issue only from IDLE.
REQ-030 A timeout and a request drop in the same cycle SHALL be treated as a normal release, with no oTIMEOUT pulse.
REQ-031 oGNT SHALL never have more than one bit set; no grant SHALL be issued while oFLASH_CS_N=0.

Reset
REQ-032 While iRESETn=0 at an edge: state=IDLE, oGNT=0, oBUSY=0, oOWNER=0, oTIMEOUT=0, gap counter=0, timeout counter=0, round-robin pointer=0.
REQ-033 After reset, the pad outputs SHALL be parked per REQ-026 in the first cycle.
REQ-034 A reset during OWN SHALL deassert oFLASH_CS_N to 1 at that edge, aborting the transfer; no GAP is inserted after reset.

Verification
REQ-035 Reset then iREQ=2'b01 -> oGNT=2'b01 one cycle later; owner iCS_N=0 with iSCK toggling -> oFLASH_SCK mirrors it; drop iREQ -> oGNT=0 at the next edge, then pGAP=2 parked cycles, then IDLE.
REQ-036 pRR=1, pCHANNELS=3, iREQ=3'b111 held with each owner releasing after 4 cycles -> grant order 0,1,2,0; with pRR=0 -> order 0,0,0.
REQ-037 pTIMEOUT=16, channel 1 holds iREQ indefinitely -> oTIMEOUT pulses at cycle 16 of the grant, oFLASH_CS_N=1 at the same edge, then GAP.
REQ-038 Owner in a quad read (iCS_N=0, iOE=0) -> oDQ_OE=0; owner raises iCS_N -> oDQ_OE=4'b1100 and oDQ_O=4'b1100.
REQ-039 iRESETn=0 during OWN with iCS_N=0 -> at that edge oFLASH_CS_N=1, oGNT=0, oOWNER=0; the first grant after reset goes to channel 0 under round-robin.
